// File: rtl/apb_resp_pkg.sv
// Shared types and the default Carfield peripheral address map for the APB responder.
package apb_resp_pkg;

    localparam int unsigned NumMapPorts  = 5;
    localparam int unsigned MapAddrWidth = 32;

    localparam int unsigned PortCan      = 0;
    localparam int unsigned PortTimer    = 1;
    localparam int unsigned PortAdvTimer = 2;
    localparam int unsigned PortWatchdog = 3;
    localparam int unsigned PortHyperBus = 4;

    typedef struct packed {
        logic [MapAddrWidth-1:0] base;
        logic [MapAddrWidth-1:0] size;
    } addr_rule_t;

    localparam addr_rule_t [NumMapPorts-1:0] DefaultMap = '{
        PortHyperBus: '{base: 32'h2000_8000, size: 32'h0000_1000},
        PortWatchdog: '{base: 32'h2000_7000, size: 32'h0000_1000},
        PortAdvTimer: '{base: 32'h2000_5000, size: 32'h0000_1000},
        PortTimer:    '{base: 32'h2000_4000, size: 32'h0000_1000},
        PortCan:      '{base: 32'h2000_1000, size: 32'h0000_1000}
    };

    typedef enum logic [2:0] {
        IDLE,
        FWD_SETUP,
        FWD_ACCESS,
        RESP,
        ERR
    } state_e;

endpackage

// File: rtl/apb_resp_decode.sv
// Combinational address decoder: per-rule match vector plus lowest-index hit and index.
module apb_resp_decode
    import apb_resp_pkg::*;
#(
    parameter int unsigned NumPorts  = NumMapPorts,
    parameter int unsigned AddrWidth = 32,
    parameter addr_rule_t [NumPorts-1:0] AddrMap = DefaultMap,
    localparam int unsigned IdxWidth = $clog2(NumPorts)
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [NumPorts-1:0]  en_i,
    output logic [NumPorts-1:0]  match_o,
    output logic                 hit_o,
    output logic [IdxWidth-1:0]  idx_o
);

    // Walk from the top so the lowest matching index is the one left standing.
    always_comb begin
        match_o = '0;
        hit_o   = 1'b0;
        idx_o   = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            match_o[i] = en_i[i]
                && (addr_i >= AddrWidth'(AddrMap[i].base))
                && ((addr_i - AddrWidth'(AddrMap[i].base)) < AddrWidth'(AddrMap[i].size));
            if (match_o[i]) begin
                hit_o = 1'b1;
                idx_o = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/apb_periph_responder.sv
// APB completer for the peripheral window: decodes, forwards to one downstream port,
// and always completes upstream (error on miss or downstream timeout).
module apb_periph_responder
    import apb_resp_pkg::*;
#(
    parameter int unsigned NumPorts      = NumMapPorts,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1023,
    parameter addr_rule_t [NumPorts-1:0] AddrMap = DefaultMap
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumPorts-1:0]           port_en_i,
    input  logic [AddrWidth-1:0]          s_paddr_i,
    input  logic                          s_psel_i,
    input  logic                          s_penable_i,
    input  logic                          s_pwrite_i,
    input  logic [DataWidth-1:0]          s_pwdata_i,
    input  logic [DataWidth/8-1:0]        s_pstrb_i,
    output logic [DataWidth-1:0]          s_prdata_o,
    output logic                          s_pready_o,
    output logic                          s_pslverr_o,
    output logic [NumPorts-1:0]           m_psel_o,
    output logic                          m_penable_o,
    output logic                          m_pwrite_o,
    output logic [AddrWidth-1:0]          m_paddr_o,
    output logic [DataWidth-1:0]          m_pwdata_o,
    output logic [DataWidth/8-1:0]        m_pstrb_o,
    input  logic [NumPorts*DataWidth-1:0] m_prdata_i,
    input  logic [NumPorts-1:0]           m_pready_i,
    input  logic [NumPorts-1:0]           m_pslverr_i,
    output logic                          timeout_o
);

    localparam int unsigned IdxWidth  = $clog2(NumPorts);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    state_e                 state_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   write_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [StrbWidth-1:0]   strb_q;
    logic [IdxWidth-1:0]    idx_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [NumPorts-1:0]    psel_q;
    logic                   penable_q;
    logic [DataWidth-1:0]   prdata_q;
    logic                   pready_q;
    logic                   pslverr_q;
    logic                   timeout_q;

    logic                   setup_c;
    logic                   dec_hit;
    logic [IdxWidth-1:0]    dec_idx;
    logic [NumPorts-1:0]    dec_match;
    logic [CntWidth-1:0]    cnt_inc;

    assign setup_c = (state_q == IDLE) && s_psel_i && !s_penable_i;
    assign cnt_inc = cnt_q + CntWidth'(1);

    apb_resp_decode #(
        .NumPorts  (NumPorts),
        .AddrWidth (AddrWidth),
        .AddrMap   (AddrMap)
    ) u_decode (
        .addr_i  (s_paddr_i),
        .en_i    (port_en_i),
        .match_o (dec_match),
        .hit_o   (dec_hit),
        .idx_o   (dec_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (setup_c) begin
                        addr_q  <= s_paddr_i;
                        write_q <= s_pwrite_i;
                        wdata_q <= s_pwdata_i;
                        strb_q  <= s_pstrb_i;
                        if (dec_hit) begin
                            idx_q            <= dec_idx;
                            psel_q           <= '0;
                            psel_q[dec_idx]  <= 1'b1;
                            state_q          <= FWD_SETUP;
                        end else begin
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                            state_q   <= ERR;
                        end
                    end
                end
                FWD_SETUP: begin
                    cnt_q   <= '0;
                    state_q <= FWD_ACCESS;
                    // A one-cycle budget is spent before the downstream ever sees ACCESS.
                    if (CntLast == '0) begin
                        psel_q    <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        penable_q <= 1'b1;
                    end
                end
                FWD_ACCESS: begin
                    if (cnt_q == CntLast) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                        state_q   <= ERR;
                    end else if (m_pready_i[idx_q]) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= m_pslverr_i[idx_q];
                        prdata_q  <= write_q ? '0
                                             : m_prdata_i[int'(idx_q)*DataWidth +: DataWidth];
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                        // Abort is announced one cycle ahead so the ERR reply follows the pulse.
                        if (cnt_inc == CntLast) begin
                            psel_q    <= '0;
                            penable_q <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                RESP, ERR: begin
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_prdata_o  = prdata_q;
    assign s_pready_o  = pready_q;
    assign s_pslverr_o = pslverr_q;
    assign m_psel_o    = psel_q;
    assign m_penable_o = penable_q;
    assign m_pwrite_o  = write_q;
    assign m_paddr_o   = addr_q;
    assign m_pwdata_o  = wdata_q;
    assign m_pstrb_o   = strb_q;
    assign timeout_o   = timeout_q;

    overlap_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        setup_c |-> $onehot0(dec_match));

    psel_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != IDLE) |-> s_psel_i);

endmodule

// File: tb/tb_apb_periph_responder.sv
// Directed bench for apb_periph_responder with a cycle-level reference model of the transfer.
module tb_apb_periph_responder;

    localparam int TC = 8;
    localparam logic [31:0] MapBase [5] = '{32'h2000_1000, 32'h2000_4000, 32'h2000_5000,
                                            32'h2000_7000, 32'h2000_8000};

    logic         clk = 1'b0;
    logic         rst_ni = 1'b1;
    logic [4:0]   port_en_i = '0;
    logic [31:0]  s_paddr_i = '0;
    logic         s_psel_i = 1'b0;
    logic         s_penable_i = 1'b0;
    logic         s_pwrite_i = 1'b0;
    logic [31:0]  s_pwdata_i = '0;
    logic [3:0]   s_pstrb_i = '0;
    logic [31:0]  s_prdata_o;
    logic         s_pready_o;
    logic         s_pslverr_o;
    logic [4:0]   m_psel_o;
    logic         m_penable_o;
    logic         m_pwrite_o;
    logic [31:0]  m_paddr_o;
    logic [31:0]  m_pwdata_o;
    logic [3:0]   m_pstrb_o;
    logic [159:0] m_prdata_i = '0;
    logic [4:0]   m_pready_i = '0;
    logic [4:0]   m_pslverr_i = '0;
    logic         timeout_o;

    apb_periph_responder #(.TimeoutCycles(TC)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .port_en_i   (port_en_i),
        .s_paddr_i   (s_paddr_i),
        .s_psel_i    (s_psel_i),
        .s_penable_i (s_penable_i),
        .s_pwrite_i  (s_pwrite_i),
        .s_pwdata_i  (s_pwdata_i),
        .s_pstrb_i   (s_pstrb_i),
        .s_prdata_o  (s_prdata_o),
        .s_pready_o  (s_pready_o),
        .s_pslverr_o (s_pslverr_o),
        .m_psel_o    (m_psel_o),
        .m_penable_o (m_penable_o),
        .m_pwrite_o  (m_pwrite_o),
        .m_paddr_o   (m_paddr_o),
        .m_pwdata_o  (m_pwdata_o),
        .m_pstrb_o   (m_pstrb_o),
        .m_prdata_i  (m_prdata_i),
        .m_pready_i  (m_pready_i),
        .m_pslverr_i (m_pslverr_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    endtask

    // Current transaction as seen by the model
    bit          tr_active = 0;
    int          tr_t0, tr_port, tr_stall, tr_R;
    bit          tr_to;
    logic [31:0] tr_addr, tr_wdata, tr_rdata;
    logic [3:0]  tr_strb;
    logic [4:0]  tr_en;
    logic        tr_write, tr_err;

    // DUT observations for the literal checks
    int          obs_resp_k, obs_to_k, obs_to_cnt;
    logic [31:0] obs_data;
    logic        obs_err;
    logic [4:0]  obs_sel;

    function automatic int decode_port(input logic [31:0] a, input logic [4:0] en);
        for (int i = 0; i < 5; i++)
            if (en[i] && a >= MapBase[i] && (a - MapBase[i]) < 32'h1000) return i;
        return -1;
    endfunction

    // Accepted iff downstream readies before the counter hits its last value.
    function automatic bit times_out(input int port, input int stall);
        return port >= 0 && !(stall >= 0 && stall <= TC - 2);
    endfunction

    function automatic int resp_cycle(input int port, input int stall);
        if (port < 0) return 1;
        if (times_out(port, stall)) return TC + 2;
        return 3 + stall;
    endfunction

    task automatic drive_down(input int k);
        logic [4:0] tgt;
        tgt = '0;
        if (tr_port >= 0) tgt[tr_port] = 1'b1;
        // Non-target ports answer instantly with an error and junk data.
        m_pready_i  = ~tgt | ((tr_stall >= 0 && k == 2 + tr_stall) ? tgt : 5'b0);
        m_pslverr_i = ~tgt | (tr_err ? tgt : 5'b0);
        for (int p = 0; p < 5; p++)
            m_prdata_i[p*32 +: 32] = (p == tr_port) ? tr_rdata : (32'hBAD0_0000 | 32'(p));
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [3:0] st, input logic [4:0] en, input int stall,
                              input logic [31:0] rd, input logic err);
        @(posedge clk); #1;
        tr_addr = a; tr_write = w; tr_wdata = wd; tr_strb = st; tr_en = en;
        tr_stall = stall; tr_rdata = rd; tr_err = err;
        tr_port = decode_port(a, en);
        tr_to   = times_out(tr_port, stall);
        tr_R    = resp_cycle(tr_port, stall);
        tr_t0   = cyc;
        obs_resp_k = -1; obs_to_k = -1; obs_to_cnt = 0; obs_data = 'x; obs_err = 'x; obs_sel = '0;
        tr_active = 1;
        port_en_i = en; s_paddr_i = a; s_pwrite_i = w; s_pwdata_i = wd; s_pstrb_i = st;
        s_psel_i = 1'b1; s_penable_i = 1'b0;
        drive_down(0);
    endtask

    // Enables flip after decode; the transfer in flight must not notice.
    task automatic step_xfer();
        @(posedge clk); #1;
        s_penable_i = 1'b1;
        port_en_i   = ~tr_en;
        drive_down(cyc - tr_t0);
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                            input logic [3:0] st, input logic [4:0] en, input int stall,
                            input logic [31:0] rd, input logic err);
        start_xfer(a, w, wd, st, en, stall, rd, err);
        for (int k = 1; k <= tr_R; k++) step_xfer();
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        tr_active = 0;
        s_psel_i = 1'b0; s_penable_i = 1'b0;
        m_pready_i = '0; m_pslverr_i = '0;
        repeat (n - 1) @(posedge clk);
    endtask

    // Per-cycle comparison against the model
    int          ck, last_sel;
    logic [4:0]  e_sel;
    logic        e_pen, e_rdy, e_err, e_to;
    logic [31:0] e_data;

    always @(negedge clk) begin
        if (!rst_ni) begin
            chk("rst_psel",    32'(m_psel_o), 32'd0);
            chk("rst_penable", 32'(m_penable_o), 32'd0);
            chk("rst_pready",  32'(s_pready_o), 32'd0);
            chk("rst_pslverr", 32'(s_pslverr_o), 32'd0);
            chk("rst_prdata",  s_prdata_o, 32'd0);
            chk("rst_timeout", 32'(timeout_o), 32'd0);
            chk("rst_paddr",   m_paddr_o, 32'd0);
            chk("rst_pwdata",  m_pwdata_o, 32'd0);
        end else if (!tr_active) begin
            chk("idle_psel",    32'(m_psel_o), 32'd0);
            chk("idle_penable", 32'(m_penable_o), 32'd0);
            chk("idle_pready",  32'(s_pready_o), 32'd0);
            chk("idle_timeout", 32'(timeout_o), 32'd0);
        end else begin
            ck       = cyc - tr_t0;
            last_sel = tr_to ? TC : 2 + tr_stall;
            e_sel    = '0;
            if (tr_port >= 0 && ck >= 1 && ck <= last_sel) e_sel[tr_port] = 1'b1;
            e_pen  = tr_port >= 0 && ck >= 2 && ck <= last_sel;
            e_rdy  = ck == tr_R;
            e_err  = e_rdy && (tr_port < 0 || tr_to || tr_err);
            e_data = (e_rdy && tr_port >= 0 && !tr_to && !tr_write) ? tr_rdata : 32'd0;
            e_to   = tr_to && ck == TC + 1;
            chk("psel",    32'(m_psel_o), 32'(e_sel));
            chk("penable", 32'(m_penable_o), 32'(e_pen));
            chk("pready",  32'(s_pready_o), 32'(e_rdy));
            chk("pslverr", 32'(s_pslverr_o), 32'(e_err));
            chk("prdata",  s_prdata_o, e_data);
            chk("timeout", 32'(timeout_o), 32'(e_to));
            if (e_sel != 0) begin
                chk("paddr",  m_paddr_o, tr_addr);
                chk("pwrite", 32'(m_pwrite_o), 32'(tr_write));
                chk("pwdata", m_pwdata_o, tr_wdata);
                chk("pstrb",  32'(m_pstrb_o), 32'(tr_strb));
            end
            obs_sel |= m_psel_o;
            if (s_pready_o) begin
                obs_resp_k = ck; obs_data = s_prdata_o; obs_err = s_pslverr_o;
            end
            if (timeout_o) begin
                obs_to_k = ck; obs_to_cnt++;
            end
        end
    end

    initial begin
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        idle(2);

        // Timer read, immediate ready
        run_xfer(32'h2000_4010, 1'b0, 32'h0, 4'h0, 5'h1F, 0, 32'hCAFE_0001, 1'b0);
        idle(1);
        chk("t1_resp_k", 32'(obs_resp_k), 32'd3);
        chk("t1_data",   obs_data, 32'hCAFE_0001);
        chk("t1_err",    32'(obs_err), 32'd0);
        chk("t1_sel",    32'(obs_sel), 32'b00010);

        // HyperBus write with 3 wait states, back-to-back with a CAN read at its last word
        run_xfer(32'h2000_8004, 1'b1, 32'hA5A5_A5A5, 4'hF, 5'h1F, 3, 32'h1234_5678, 1'b0);
        run_xfer(32'h2000_1FFC, 1'b0, 32'h0, 4'h0, 5'h1F, 1, 32'h0BAD_CAFE, 1'b1);
        idle(1);
        chk("b2b_resp_k", 32'(obs_resp_k), 32'd4);
        chk("b2b_err",    32'(obs_err), 32'd1);
        chk("b2b_sel",    32'(obs_sel), 32'b00001);

        run_xfer(32'h2000_8004, 1'b1, 32'hA5A5_A5A5, 4'hF, 5'h1F, 3, 32'h1234_5678, 1'b0);
        idle(1);
        chk("t2_resp_k", 32'(obs_resp_k), 32'd6);
        chk("t2_data",   obs_data, 32'd0);
        chk("t2_err",    32'(obs_err), 32'd0);

        // Hole between Timer/AdvTimer and Watchdog
        run_xfer(32'h2000_6000, 1'b0, 32'h0, 4'h0, 5'h1F, 0, 32'h0, 1'b0);
        idle(1);
        chk("hole_resp_k", 32'(obs_resp_k), 32'd1);
        chk("hole_err",    32'(obs_err), 32'd1);
        chk("hole_data",   obs_data, 32'd0);
        chk("hole_sel",    32'(obs_sel), 32'd0);

        // CAN disabled
        run_xfer(32'h2000_1000, 1'b0, 32'h0, 4'h0, 5'b11110, 0, 32'h0, 1'b0);
        idle(1);
        chk("dis_resp_k", 32'(obs_resp_k), 32'd1);
        chk("dis_err",    32'(obs_err), 32'd1);
        chk("dis_sel",    32'(obs_sel), 32'd0);

        // Edges just outside the CAN window
        run_xfer(32'h2000_2000, 1'b0, 32'h0, 4'h0, 5'h1F, 0, 32'h0, 1'b0);
        run_xfer(32'h2000_0FFF, 1'b1, 32'h55, 4'h1, 5'h1F, 0, 32'h0, 1'b0);
        idle(1);

        // Watchdog ready on the last cycle before the abort
        run_xfer(32'h2000_7008, 1'b0, 32'h0, 4'h0, 5'h1F, TC - 2, 32'h7777_0003, 1'b0);
        idle(1);
        chk("late_resp_k", 32'(obs_resp_k), 32'd9);
        chk("late_data",   obs_data, 32'h7777_0003);

        // Watchdog never ready: timeout, then a normal Timer access
        run_xfer(32'h2000_7000, 1'b0, 32'h0, 4'h0, 5'h1F, -1, 32'hDEAD_BEEF, 1'b0);
        idle(1);
        chk("to_k",      32'(obs_to_k), 32'd9);
        chk("to_cnt",    32'(obs_to_cnt), 32'd1);
        chk("to_resp_k", 32'(obs_resp_k), 32'd10);
        chk("to_err",    32'(obs_err), 32'd1);
        chk("to_data",   obs_data, 32'd0);
        run_xfer(32'h2000_4000, 1'b0, 32'h0, 4'h0, 5'h1F, 2, 32'h1111_2222, 1'b0);
        idle(1);
        chk("after_to_resp_k", 32'(obs_resp_k), 32'd5);
        chk("after_to_data",   obs_data, 32'h1111_2222);

        // Reset while AdvTimer is in ACCESS
        start_xfer(32'h2000_5000, 1'b0, 32'h0, 4'h0, 5'h1F, -1, 32'h0, 1'b0);
        for (int k = 1; k <= 3; k++) step_xfer();
        #2 rst_ni = 1'b0;
        tr_active = 0;
        #1;
        chk("abort_psel",    32'(m_psel_o), 32'd0);
        chk("abort_penable", 32'(m_penable_o), 32'd0);
        chk("abort_pready",  32'(s_pready_o), 32'd0);
        s_psel_i = 1'b0; s_penable_i = 1'b0; m_pready_i = '0; m_pslverr_i = '0;
        @(posedge clk); #1 rst_ni = 1'b1;
        idle(2);
        run_xfer(32'h2000_5010, 1'b0, 32'h0, 4'h0, 5'h1F, 0, 32'h2222_0002, 1'b0);
        idle(2);
        chk("rst_fresh_resp_k", 32'(obs_resp_k), 32'd3);
        chk("rst_fresh_data",   obs_data, 32'h2222_0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_periph_responder.md
# apb_periph_responder

APB completer for the Carfield peripheral window. It accepts one APB transfer at a time from the upstream AXI-to-APB bridge and decodes its address against the peripheral map: CAN, system timer, advanced timer, watchdog and HyperBus config. It forwards each hit to the matching downstream APB port and returns the completion upstream. Unmapped or disabled addresses, and downstream stalls, get a deterministic error response, so the bridge can never hang.

## Interface
- NumPorts, 5, downstream APB ports; index order CAN=0, Timer=1, AdvTimer=2, Watchdog=3, HyperBus=4
- AddrWidth, 32, APB address width
- DataWidth, 32, APB data width; strobe width is DataWidth/8
- TimeoutCycles, 1023, maximum downstream ACCESS cycles before abort; must be ≥1
- AddrMap, apb_resp_pkg::DefaultMap, per-port {base, size}; defaults 0x2000_1000, 0x2000_4000, 0x2000_5000, 0x2000_7000, 0x2000_8000, each with size 0x1000
- Clock and reset: one clock; reset is asynchronous and active-low. Both are listed first among the ports below.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- port_en_i  in  NumPorts  per-port enable; a disabled port decodes as unmapped
- s_paddr_i  in  AddrWidth  upstream address
- s_psel_i, s_penable_i, s_pwrite_i  in  1 each  upstream APB control
- s_pwdata_i  in  DataWidth  upstream write data
- s_pstrb_i  in  DataWidth/8  upstream write strobes
- s_prdata_o  out  DataWidth  upstream read data
- s_pready_o, s_pslverr_o  out  1 each  upstream completion
- m_psel_o  out  NumPorts  one-hot downstream select
- m_penable_o, m_pwrite_o  out  1 each  shared downstream control
- m_paddr_o  out  AddrWidth  shared downstream address
- m_pwdata_o  out  DataWidth  shared downstream write data
- m_pstrb_o  out  DataWidth/8  shared downstream write strobes
- m_prdata_i  in  NumPorts×DataWidth  downstream read data, packed per port
- m_pready_i, m_pslverr_i  in  NumPorts each  downstream completion
- timeout_o  out  1  one-cycle pulse on each timeout abort

## Operation
- FSM states: IDLE, FWD_SETUP, FWD_ACCESS, RESP, ERR.
- IDLE: on s_psel_i=1 and s_penable_i=0, latch addr, write, wdata and strb. Then decode.
  - Hit condition for port i: base ≤ addr < base+size, and port_en_i[i]=1.
  - If several ports hit, the lowest index wins. Overlaps are illegal; an SVA flags them.
  - Hit → FWD_SETUP with the index latched. No hit → ERR.
- FWD_SETUP: m_psel_o[idx]=1, m_penable_o=0. Next state is FWD_ACCESS.
- FWD_ACCESS: m_psel_o[idx]=1, m_penable_o=1, timeout counter increments every cycle.
  - m_pready_i[idx]=1 → capture prdata (writes capture 0) and pslverr, go to RESP.
  - Counter reaches TimeoutCycles-1 without pready → drop m_psel/m_penable, pulse timeout_o, go to ERR.
- RESP: s_pready_o=1 for one cycle with the captured data and error. Next state is IDLE.
- ERR: s_pready_o=1, s_pslverr_o=1, s_prdata_o=0 for one cycle. Next state is IDLE.
- s_pready_o is 0 in every other state. Responses are driven from registers, with no combinational path from downstream to upstream.
- Downstream address is the full latched address, not rebased. m_pwrite/m_pwdata/m_pstrb/m_paddr hold latched values and are valid whenever any m_psel_o bit is set.
- Upstream protocol violations, such as dropping s_psel_i mid-transfer, are not recovered. The FSM completes the transfer it latched; an SVA flags the violation.
- port_en_i is sampled only at decode. A change mid-transfer does not affect the transfer in flight.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counter 0.
- Reset mid-transfer aborts immediately: m_psel_o=0, and no upstream response is produced.
- Mapped access, downstream pready on its first ACCESS cycle:
  - upstream SETUP at T0, m_psel at T1, m_penable at T2, s_pready at T3.
  - Each downstream wait cycle adds one upstream cycle.
- Unmapped access: upstream SETUP at T0, s_pready=1 with s_pslverr=1 at T1, giving zero upstream wait states.
- Timeout: ERR response arrives TimeoutCycles+2 cycles after T0. timeout_o pulses in the cycle before s_pready.
- Back-to-back: a new SETUP is accepted in the cycle after s_pready, because the FSM is back in IDLE.
- Counter width is $clog2(TimeoutCycles+1). It clears on entry to FWD_ACCESS and never wraps.

## Structure
- Package apb_resp_pkg holds:
  - addr_rule_t {base, size}
  - the port-index localparams
  - DefaultMap, with the values above
  - state_e
- One natural sub-module: apb_resp_decode, a combinational address-to-{hit, idx} priority decoder, reusable by the RegBus window.

## Test plan
- Read at 0x2000_4010, port 1 returns 0xCAFE_0001 with pready on the first ACCESS cycle → only m_psel_o[1] asserts; s_prdata_o=0xCAFE_0001, s_pslverr_o=0, s_pready_o at T3.
- Write 0xA5A5_A5A5 with strb 0xF to 0x2000_8004, port 4 stalls 3 cycles → m_pwdata_o and m_pstrb_o stable throughout; s_pready_o at T6, no error.
- Read at 0x2000_6000 (hole between ports) → s_pready_o=1, s_pslverr_o=1, s_prdata_o=0 at T1; no m_psel_o bit ever asserts.
- Clear port_en_i[0], then access 0x2000_1000 → error response at T1; CAN select never asserts.
- TimeoutCycles=8, port 3 never readies → m_psel_o drops, timeout_o pulses once, error response at T10; a following access to port 1 completes normally.
- Assert rst_ni low during FWD_ACCESS → all outputs 0 asynchronously; after release, a fresh read to port 2 completes at T3.
